// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: single-outstanding INCR read/write bursts served from an internal word RAM.
// Latency: first R beat R_LATENCY+1 cycles after the AR handshake; B valid the cycle after the last W beat.
// Backpressure: R data/last/resp held while !i_r_ready, B held until i_b_ready; AR/AW ready only in IDLE.
module axi_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 4096,
  parameter int R_LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_ar_valid,
  output logic                    o_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   i_ar_addr,
  input  logic [7:0]              i_ar_len,
  output logic                    o_r_valid,
  input  logic                    i_r_ready,
  output logic [DATA_WIDTH-1:0]   o_r_data,
  output logic                    o_r_last,
  output logic [1:0]              o_r_resp,
  input  logic                    i_aw_valid,
  output logic                    o_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   i_aw_addr,
  input  logic [7:0]              i_aw_len,
  input  logic                    i_w_valid,
  output logic                    o_w_ready,
  input  logic [DATA_WIDTH-1:0]   i_w_data,
  input  logic [DATA_WIDTH/8-1:0] i_w_strb,
  input  logic                    i_w_last,
  output logic                    o_b_valid,
  input  logic                    i_b_ready,
  output logic [1:0]              o_b_resp
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int BSH = (NB > 1) ? $clog2(NB) : 0;
  localparam int MW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_WORDS);
  // Only consulted in R_WAIT, which is never entered when R_LATENCY is 0.
  localparam logic [15:0] LAT_LAST = 16'(R_LATENCY - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_R_WAIT  = 3'd1;
  localparam logic [2:0] S_R_BURST = 3'd2;
  localparam logic [2:0] S_W_BURST = 3'd3;
  localparam logic [2:0] S_B_RESP  = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [7:0]            len_q, len_d;
  logic [15:0]           lat_q, lat_d;
  logic                  b_err_q, b_err_d;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                  r_last_q;
  logic [1:0]            r_resp_q;

  logic                  ar_hs, aw_hs, r_hs, w_hs;
  logic                  last_beat, w_in_range, rd_in_range, mem_we, r_load;
  logic [DATA_WIDTH-1:0] rd_word;

  // Channel handshakes; readies are held low while reset is asserted, and AW wins a same-cycle tie.
  always_comb begin
    o_aw_ready = !rst && (state_q == S_IDLE);
    o_ar_ready = !rst && (state_q == S_IDLE) && !i_aw_valid;
    o_w_ready  = !rst && (state_q == S_W_BURST);
    o_r_valid  = (state_q == S_R_BURST);
    o_b_valid  = (state_q == S_B_RESP);
    o_b_resp   = (state_q == S_B_RESP && b_err_q) ? RESP_SLVERR : RESP_OKAY;
    o_r_data   = r_data_q;
    o_r_last   = r_last_q;
    o_r_resp   = r_resp_q;
    ar_hs      = i_ar_valid && o_ar_ready;
    aw_hs      = i_aw_valid && o_aw_ready;
    r_hs       = o_r_valid && i_r_ready;
    w_hs       = i_w_valid && o_w_ready;
    last_beat  = (cnt_q == {1'b0, len_q});
    w_in_range = (idx_q < MEM_LIMIT);
    mem_we     = w_hs && w_in_range;
  end

  // Transaction sequencing: beat index, beat count and sticky write error.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    lat_d   = lat_q;
    b_err_d = b_err_q;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          idx_d   = i_aw_addr >> BSH;
          len_d   = i_aw_len;
          cnt_d   = 9'd0;
          b_err_d = 1'b0;
          state_d = S_W_BURST;
        end else if (ar_hs) begin
          idx_d   = i_ar_addr >> BSH;
          len_d   = i_ar_len;
          cnt_d   = 9'd0;
          lat_d   = 16'd0;
          state_d = (R_LATENCY == 0) ? S_R_BURST : S_R_WAIT;
        end
      end
      S_R_WAIT: begin
        if (lat_q == LAT_LAST) state_d = S_R_BURST;
        else                   lat_d   = lat_q + 16'd1;
      end
      S_R_BURST: begin
        if (r_hs) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      S_W_BURST: begin
        if (w_hs) begin
          idx_d = idx_q + ADDR_WIDTH'(1);
          cnt_d = cnt_q + 9'd1;
          // Out-of-range beats and a w_last that disagrees with the burst length both flag SLVERR.
          if (!w_in_range || (i_w_last != last_beat)) b_err_d = 1'b1;
          if (i_w_last || last_beat) state_d = S_B_RESP;
        end
      end
      S_B_RESP: begin
        if (i_b_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read beat source: the word the next R beat will present (zero beyond the RAM).
  always_comb begin
    rd_in_range = (idx_d < MEM_LIMIT);
    rd_word     = rd_in_range ? mem[idx_d[MW-1:0]] : '0;
    r_load      = (state_d == S_R_BURST) && ((state_q != S_R_BURST) || r_hs);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      lat_q   <= '0;
      b_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      lat_q   <= lat_d;
      b_err_q <= b_err_d;
    end
  end

  // R beat registers: loaded on burst entry and after each accepted beat, frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q <= '0;
      r_last_q <= 1'b0;
      r_resp_q <= RESP_OKAY;
    end else if (r_load) begin
      r_data_q <= rd_word;
      r_last_q <= (cnt_d == {1'b0, len_d});
      r_resp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (state_d != S_R_BURST) begin
      r_data_q <= '0;
      r_last_q <= 1'b0;
      r_resp_q <= RESP_OKAY;
    end
  end

  // RAM byte writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_w_strb[b]) mem[idx_q[MW-1:0]][b*8 +: 8] <= i_w_data[b*8 +: 8];
      end
    end
  end

endmodule
